sdrc_bank_sched: RTL and testbench

- Four-bank command scheduler between the per-bank FSMs and the transfer controller.
- Collects b2x-style requests (PRE/ACT/RD/WR) from up to 4 bank FSMs and grants one per cycle to the single xfr_ctl command port.
- Arbitration: round-robin, optional row-command priority, tRRD spacing between activates.
- Provides a refresh quiesce handshake so refresh is never issued while a granted command is outstanding.

---
 rtl/sdrc_bank_sched.sv | 208 ++++++++++++++++++++
 tb/tb_sdrc_bank_sched.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sdrc_bank_sched.sv
// Four-bank command scheduler: round-robin grant of bank FSM requests
// onto the single xfr_ctl port, with row priority, tRRD and refresh quiesce.
//
// Ports:
//   clk, reset_n              clock, synchronous active-low reset
//   b2s_req/cmd/addr/len/id   per-bank request bundle, bank i in slice i
//   s2b_ack                   one-hot accept back to the granted bank
//   s2x_req/cmd/ba/addr/len/id granted command to xfr_ctl
//   x2s_ack                   xfr_ctl accepts the current command
//   row_pri                   PRE/ACT win over RD/WR when set
//   trrd_delay                ACT-to-ACT spacing in cycles
//   ref_req, ref_gnt          refresh quiesce handshake

`ifndef OP_PRE
`define OP_PRE 2'b00
`endif
`ifndef OP_ACT
`define OP_ACT 2'b01
`endif
`ifndef OP_RD
`define OP_RD 2'b10
`endif
`ifndef OP_WR
`define OP_WR 2'b11
`endif
`ifndef REQ_BW
`define REQ_BW 12
`endif
`ifndef SDR_REQ_ID_W
`define SDR_REQ_ID_W 4
`endif

module sdrc_bank_sched #(
  parameter int NB = 4,
  parameter int RW = 13,
  parameter int LW = `REQ_BW,
  parameter int IW = `SDR_REQ_ID_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [NB-1:0]    b2s_req,
  input  logic [2*NB-1:0]  b2s_cmd,
  input  logic [RW*NB-1:0] b2s_addr,
  input  logic [LW*NB-1:0] b2s_len,
  input  logic [IW*NB-1:0] b2s_id,
  output logic [NB-1:0]    s2b_ack,
  output logic             s2x_req,
  output logic [1:0]       s2x_cmd,
  output logic [1:0]       s2x_ba,
  output logic [RW-1:0]    s2x_addr,
  output logic [LW-1:0]    s2x_len,
  output logic [IW-1:0]    s2x_id,
  input  logic             x2s_ack,
  input  logic             row_pri,
  input  logic [3:0]       trrd_delay,
  input  logic             ref_req,
  output logic             ref_gnt
);

  typedef enum logic [1:0] {
    ARB  = 2'd0,
    HOLD = 2'd1,
    REF  = 2'd2
  } state_t;

  state_t        state;
  logic [1:0]    rr_ptr;
  logic [1:0]    gnt_idx;
  logic [3:0]    trrd_cnt;

  logic [1:0]    last_cmd;
  logic [1:0]    last_ba;
  logic [RW-1:0] last_addr;
  logic [LW-1:0] last_len;
  logic [IW-1:0] last_id;

  logic [NB-1:0] elig;
  logic [NB-1:0] rowc;
  logic [NB-1:0] cand;
  logic          found;
  logic [1:0]    win;
  logic [1:0]    sel;
  logic          sel_valid;
  logic          acc_act;

  always_comb begin
    elig = '0;
    rowc = '0;
    for (int i = 0; i < NB; i++) begin
      rowc[i] = (b2s_cmd[2*i +: 2] == `OP_PRE) ||
                (b2s_cmd[2*i +: 2] == `OP_ACT);
      elig[i] = b2s_req[i] &&
                !((b2s_cmd[2*i +: 2] == `OP_ACT) &&
                  (trrd_cnt != 4'd0));
    end
  end

  // Row priority narrows the field only if a row command is eligible.
  assign cand = (row_pri && |(elig & rowc)) ?
                (elig & rowc) : elig;

  // Scan downward so the entry closest to rr_ptr is kept last.
  always_comb begin
    logic [1:0] idx;
    found = 1'b0;
    win   = 2'd0;
    idx   = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      idx = rr_ptr + 2'(k);
      if (cand[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    sel       = win;
    sel_valid = 1'b0;
    s2x_req   = 1'b0;
    ref_gnt   = 1'b0;
    s2b_ack   = '0;
    if (reset_n) begin
      unique case (state)
        ARB: begin
          if (ref_req) begin
            ref_gnt = 1'b1;
          end else if (found) begin
            sel_valid = 1'b1;
            s2x_req   = 1'b1;
            if (x2s_ack)
              s2b_ack = NB'(1) << win;
          end
        end
        HOLD: begin
          sel       = gnt_idx;
          sel_valid = 1'b1;
          s2x_req   = b2s_req[gnt_idx];
          if (x2s_ack && b2s_req[gnt_idx])
            s2b_ack = NB'(1) << gnt_idx;
        end
        REF: ref_gnt = ref_req;
        default: ;
      endcase
    end
  end

  // Data outputs follow the selected bank, else keep the last values.
  assign s2x_cmd  = sel_valid ? b2s_cmd[2*sel +: 2]    : last_cmd;
  assign s2x_ba   = sel_valid ? sel                    : last_ba;
  assign s2x_addr = sel_valid ? b2s_addr[RW*sel +: RW] : last_addr;
  assign s2x_len  = sel_valid ? b2s_len[LW*sel +: LW]  : last_len;
  assign s2x_id   = sel_valid ? b2s_id[IW*sel +: IW]   : last_id;

  assign acc_act = (|s2b_ack) && (s2x_cmd == `OP_ACT);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= ARB;
      rr_ptr    <= 2'd0;
      gnt_idx   <= 2'd0;
      trrd_cnt  <= 4'd0;
      last_cmd  <= '0;
      last_ba   <= '0;
      last_addr <= '0;
      last_len  <= '0;
      last_id   <= '0;
    end else begin
      last_cmd  <= s2x_cmd;
      last_ba   <= s2x_ba;
      last_addr <= s2x_addr;
      last_len  <= s2x_len;
      last_id   <= s2x_id;
      if (acc_act)
        trrd_cnt <= trrd_delay;
      else if (trrd_cnt != 4'd0)
        trrd_cnt <= trrd_cnt - 4'd1;
      unique case (state)
        ARB: begin
          if (ref_req) begin
            state <= REF;
          end else if (found) begin
            if (x2s_ack) begin
              rr_ptr <= win + 2'd1;
            end else begin
              gnt_idx <= win;
              state   <= HOLD;
            end
          end
        end
        HOLD: begin
          if (b2s_req[gnt_idx] && x2s_ack) begin
            rr_ptr <= gnt_idx + 2'd1;
            state  <= ARB;
          end else if (!b2s_req[gnt_idx]) begin
            state <= ARB;
          end
        end
        REF: begin
          if (!ref_req)
            state <= ARB;
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_sdrc_bank_sched.sv
// Self-checking bench for sdrc_bank_sched: table of per-cycle vectors,
// expectations queued at drive time and compared at the falling edge.

module tb_sdrc_bank_sched;

  localparam int NB = 4;
  localparam int RW = 13;
  localparam int LW = 12;
  localparam int IW = 4;

  localparam logic [1:0] PRE = 2'b00;
  localparam logic [1:0] ACT = 2'b01;
  localparam logic [1:0] RD  = 2'b10;
  localparam logic [1:0] WR  = 2'b11;

  logic             clk;
  logic             reset_n;
  logic [NB-1:0]    b2s_req;
  logic [2*NB-1:0]  b2s_cmd;
  logic [RW*NB-1:0] b2s_addr;
  logic [LW*NB-1:0] b2s_len;
  logic [IW*NB-1:0] b2s_id;
  logic [NB-1:0]    s2b_ack;
  logic             s2x_req;
  logic [1:0]       s2x_cmd;
  logic [1:0]       s2x_ba;
  logic [RW-1:0]    s2x_addr;
  logic [LW-1:0]    s2x_len;
  logic [IW-1:0]    s2x_id;
  logic             x2s_ack;
  logic             row_pri;
  logic [3:0]       trrd_delay;
  logic             ref_req;
  logic             ref_gnt;

  sdrc_bank_sched #(
    .NB(NB), .RW(RW), .LW(LW), .IW(IW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .b2s_req    (b2s_req),
    .b2s_cmd    (b2s_cmd),
    .b2s_addr   (b2s_addr),
    .b2s_len    (b2s_len),
    .b2s_id     (b2s_id),
    .s2b_ack    (s2b_ack),
    .s2x_req    (s2x_req),
    .s2x_cmd    (s2x_cmd),
    .s2x_ba     (s2x_ba),
    .s2x_addr   (s2x_addr),
    .s2x_len    (s2x_len),
    .s2x_id     (s2x_id),
    .x2s_ack    (x2s_ack),
    .row_pri    (row_pri),
    .trrd_delay (trrd_delay),
    .ref_req    (ref_req),
    .ref_gnt    (ref_gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic [7:0] cmd;
    logic       ack;
    logic       rp;
    logic       rq;
    logic [3:0] trrd;
    logic       e_req;
    logic [1:0] e_ba;
    logic [1:0] e_cmd;
    logic [3:0] e_sack;
    logic       e_rg;
    logic       e_zero;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   checks;
  int   errors;

  function automatic vec_t v(
    input logic rst_n, input logic [3:0] req,
    input logic [7:0] cmd, input logic ack,
    input logic rp, input logic rq, input logic [3:0] trrd,
    input logic e_req, input logic [1:0] e_ba,
    input logic [1:0] e_cmd, input logic [3:0] e_sack,
    input logic e_rg);
    vec_t t;
    t.rst_n  = rst_n;
    t.req    = req;
    t.cmd    = cmd;
    t.ack    = ack;
    t.rp     = rp;
    t.rq     = rq;
    t.trrd   = trrd;
    t.e_req  = e_req;
    t.e_ba   = e_ba;
    t.e_cmd  = e_cmd;
    t.e_sack = e_sack;
    t.e_rg   = e_rg;
    t.e_zero = 1'b0;
    return t;
  endfunction

  task automatic chk(input string name, input int row,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h expected %0h",
               name, row, act, exp);
    end
  endtask

  task automatic check(input int row);
    vec_t e;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard row %0d: got empty expected entry",
               row);
      return;
    end
    e = sb.pop_front();
    chk("s2x_req", row, 32'(s2x_req), 32'(e.e_req));
    chk("s2b_ack", row, 32'(s2b_ack), 32'(e.e_sack));
    chk("ref_gnt", row, 32'(ref_gnt), 32'(e.e_rg));
    if (e.e_req) begin
      chk("s2x_ba", row, 32'(s2x_ba), 32'(e.e_ba));
      chk("s2x_cmd", row, 32'(s2x_cmd), 32'(e.e_cmd));
      chk("s2x_addr", row, 32'(s2x_addr),
          32'(13'h100 + 13'(e.e_ba)));
      chk("s2x_len", row, 32'(s2x_len),
          32'(12'h010 + 12'(e.e_ba)));
      chk("s2x_id", row, 32'(s2x_id), 32'(4'h8 + 4'(e.e_ba)));
    end
    if (e.e_zero) begin
      chk("rst_cmd", row, 32'(s2x_cmd), 32'd0);
      chk("rst_ba", row, 32'(s2x_ba), 32'd0);
      chk("rst_addr", row, 32'(s2x_addr), 32'd0);
      chk("rst_len", row, 32'(s2x_len), 32'd0);
      chk("rst_id", row, 32'(s2x_id), 32'd0);
    end
  endtask

  task automatic apply(input vec_t t, input int row);
    reset_n    = t.rst_n;
    b2s_req    = t.req;
    b2s_cmd    = t.cmd;
    x2s_ack    = t.ack;
    row_pri    = t.rp;
    ref_req    = t.rq;
    trrd_delay = t.trrd;
    sb.push_back(t);
    @(negedge clk);
    check(row);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t r;
    checks  = 0;
    errors  = 0;
    reset_n = 1'b0;
    b2s_req = '0;
    b2s_cmd = '0;
    x2s_ack = 1'b0;
    row_pri = 1'b0;
    ref_req = 1'b0;
    trrd_delay = 4'd0;
    for (int i = 0; i < NB; i++) begin
      b2s_addr[RW*i +: RW] = 13'h100 + 13'(i);
      b2s_len[LW*i +: LW]  = 12'h010 + 12'(i);
      b2s_id[IW*i +: IW]   = 4'h8 + 4'(i);
    end

    // reset
    tbl.push_back(v(0, 4'h0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0));
    r = v(0, 4'h0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0);
    r.e_zero = 1'b1;
    tbl.push_back(r);
    // round robin, all banks RD, ack every cycle
    tbl.push_back(v(1, 4'hf, 8'haa, 1, 0, 0, 0, 1, 0, RD, 4'h1, 0));
    tbl.push_back(v(1, 4'hf, 8'haa, 1, 0, 0, 0, 1, 1, RD, 4'h2, 0));
    tbl.push_back(v(1, 4'hf, 8'haa, 1, 0, 0, 0, 1, 2, RD, 4'h4, 0));
    tbl.push_back(v(1, 4'hf, 8'haa, 1, 0, 0, 0, 1, 3, RD, 4'h8, 0));
    tbl.push_back(v(1, 4'hf, 8'haa, 1, 0, 0, 0, 1, 0, RD, 4'h1, 0));
    // bring rr_ptr back to 0, then row priority
    tbl.push_back(v(1, 4'h8, 8'haa, 1, 0, 0, 0, 1, 3, RD, 4'h8, 0));
    tbl.push_back(v(1, 4'h6, 8'h8a, 1, 1, 0, 0, 1, 2, PRE, 4'h4, 0));
    tbl.push_back(v(1, 4'h2, 8'h8a, 1, 1, 0, 0, 1, 1, RD, 4'h2, 0));
    // tRRD = 3: bank0 ACT, bank1 ACT masked 3 cycles, bank2 RD passes
    tbl.push_back(v(1, 4'h1, 8'ha9, 1, 0, 0, 3, 1, 0, ACT, 4'h1, 0));
    tbl.push_back(v(1, 4'h2, 8'ha6, 1, 0, 0, 3, 0, 0, 0, 4'h0, 0));
    tbl.push_back(v(1, 4'h6, 8'ha6, 1, 0, 0, 3, 1, 2, RD, 4'h4, 0));
    tbl.push_back(v(1, 4'h2, 8'ha6, 1, 0, 0, 3, 0, 0, 0, 4'h0, 0));
    tbl.push_back(v(1, 4'h2, 8'ha6, 1, 0, 0, 3, 1, 1, ACT, 4'h2, 0));
    // hold bank3 WR for 5 cycles, bank0 ignored, then withdraw
    tbl.push_back(v(1, 4'h8, 8'hea, 0, 0, 0, 3, 1, 3, WR, 4'h0, 0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(v(1, 4'h9, 8'hea, 0, 0, 0, 3, 1, 3, WR, 4'h0, 0));
    tbl.push_back(v(1, 4'h1, 8'hea, 0, 0, 0, 3, 0, 0, 0, 4'h0, 0));
    tbl.push_back(v(1, 4'h1, 8'hea, 1, 0, 0, 3, 1, 0, RD, 4'h1, 0));
    // refresh raised during HOLD
    tbl.push_back(v(1, 4'h2, 8'haa, 0, 0, 0, 0, 1, 1, RD, 4'h0, 0));
    tbl.push_back(v(1, 4'h2, 8'haa, 0, 0, 1, 0, 1, 1, RD, 4'h0, 0));
    tbl.push_back(v(1, 4'h2, 8'haa, 1, 0, 1, 0, 1, 1, RD, 4'h2, 0));
    tbl.push_back(v(1, 4'h4, 8'haa, 0, 0, 1, 0, 0, 0, 0, 4'h0, 1));
    tbl.push_back(v(1, 4'h4, 8'haa, 0, 0, 1, 0, 0, 0, 0, 4'h0, 1));
    tbl.push_back(v(1, 4'h4, 8'haa, 1, 0, 0, 0, 0, 0, 0, 4'h0, 0));
    tbl.push_back(v(1, 4'h4, 8'haa, 1, 0, 0, 0, 1, 2, RD, 4'h4, 0));

    for (int i = 0; i < tbl.size(); i++)
      apply(tbl[i], i);

    // reset during HOLD clears rr_ptr and trrd_cnt
    apply(v(1, 4'h1, 8'ha9, 1, 0, 0, 7, 1, 0, ACT, 4'h1, 0), 100);
    apply(v(1, 4'h4, 8'hb9, 0, 0, 0, 7, 1, 2, WR, 4'h0, 0), 101);
    apply(v(0, 4'h4, 8'hb9, 0, 0, 0, 7, 0, 0, 0, 4'h0, 0), 102);
    apply(v(1, 4'h9, 8'ha9, 1, 0, 0, 7, 1, 0, ACT, 4'h1, 0), 103);

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: got %0d leftover expected 0",
               sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
